wb_burst_ram: RTL

WB_BURST_RAM -- requirements
Module: wb_burst_ram

---
 rtl/wb_burst_ram_if.sv | 27 ++
 rtl/wb_burst_ram.sv | 104 ++++++++++
 2 files changed

// File: rtl/wb_burst_ram_if.sv
// Wishbone B4 bus bundle for the burst-capable RAM slave.
// Signal names follow the slave's point of view (_i driven by master, _o by slave).
interface wb_burst_ram_if #(
  parameter int c_DATA_WIDTH = 64
);
  logic [31:0]               wb_adr_i;
  logic [c_DATA_WIDTH-1:0]   wb_dat_i;
  logic [c_DATA_WIDTH/8-1:0] wb_sel_i;
  logic                      wb_we_i;
  logic                      wb_cyc_i;
  logic                      wb_stb_i;
  logic [2:0]                wb_cti_i;
  logic [c_DATA_WIDTH-1:0]   wb_dat_o;
  logic                      wb_ack_o;
  logic                      wb_err_o;
  logic                      wb_rty_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_burst_ram.sv
// Wishbone slave RAM (2^ADDR_BITS x 64-bit words) with classic cycles and
// zero-wait incrementing bursts. Misses and misaligned addresses get a
// one-cycle error. Burst read data is prefetched one word ahead.
module wb_burst_ram #(
  parameter int          c_DATA_WIDTH = 64,
  parameter logic [31:0] BASE         = 32'h0000,
  parameter int          ADDR_BITS    = 10
) (
  input  logic             clk,
  input  logic             rstn,
  wb_burst_ram_if.slave    wb
);

  localparam int c_SEL_W = c_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLASSIC = 2'd1,
    BURST   = 2'd2,
    ERR     = 2'd3
  } state_t;

  localparam logic [2:0] c_CTI_INCR = 3'b010;
  localparam logic [2:0] c_CTI_EOB  = 3'b111;

  state_t                  r_state;
  logic [ADDR_BITS-1:0]    r_cnt;       // word being served (classic or burst)
  logic [c_DATA_WIDTH-1:0] r_rd;        // prefetched word for the next acked beat
  logic [c_DATA_WIDTH-1:0] r_last;      // last word presented, held while not acking
  logic                    r_err;
  logic [c_DATA_WIDTH-1:0] r_mem [2**ADDR_BITS];

  logic                    w_req;
  logic                    w_hit;
  logic [ADDR_BITS-1:0]    w_idx;
  logic [ADDR_BITS-1:0]    w_cnt_nxt;
  logic                    w_ack;

  assign w_req     = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_hit     = (wb.wb_adr_i[31:ADDR_BITS+3] == BASE[31:ADDR_BITS+3]) &&
                     (wb.wb_adr_i[2:0] == 3'b000);
  assign w_idx     = wb.wb_adr_i[ADDR_BITS+2:3];
  assign w_cnt_nxt = r_cnt + 1'b1;  // wraps modulo 2^ADDR_BITS by width

  // Ack is gated live by cyc/stb so master wait states and aborts cost no beat.
  assign w_ack = ((r_state == CLASSIC) || (r_state == BURST)) && w_req;

  assign wb.wb_ack_o = w_ack;
  assign wb.wb_err_o = r_err;
  assign wb.wb_dat_o = w_ack ? r_rd : r_last;
  assign wb.wb_rty_o = 1'b0;

  // Transfer state machine, word counter and read-data prefetch.
  // NOTE: every register here uses <= so all next-state terms see pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_last  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_ack) r_last <= r_rd;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (!w_hit) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else begin
              r_cnt   <= w_idx;
              r_rd    <= r_mem[w_idx];
              r_state <= (wb.wb_cti_i == c_CTI_INCR) ? BURST : CLASSIC;
            end
          end
        end
        CLASSIC: r_state <= IDLE;
        BURST: begin
          if (!wb.wb_cyc_i) begin
            r_state <= IDLE;
          end else if (w_ack) begin
            r_cnt <= w_cnt_nxt;
            r_rd  <= r_mem[w_cnt_nxt];
            if (wb.wb_cti_i == c_CTI_EOB) r_state <= IDLE;
          end
        end
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Byte-lane writes on acked write beats.
  // NOTE: the storage array has no reset; contents survive rstn and map to plain RAM.
  always_ff @(posedge clk) begin
    if (w_ack && wb.wb_we_i) begin
      for (int k = 0; k < c_SEL_W; k++) begin
        if (wb.wb_sel_i[k]) r_mem[r_cnt][8*k +: 8] <= wb.wb_dat_i[8*k +: 8];
      end
    end
  end

endmodule
